// File: rtl/xgmii_pkg.sv
// XGMII control codes, aligned start-word pattern and rx frame FSM encoding
// shared by the rx frame delineator.
package xgmii_pkg;

   localparam logic [7:0] XgmiiStart    = 8'hFB;
   localparam logic [7:0] XgmiiTerm     = 8'hFD;
   localparam logic [7:0] XgmiiError    = 8'hFE;
   localparam logic [7:0] XgmiiIdle     = 8'h07;
   localparam logic [7:0] XgmiiPreamble = 8'h55;
   localparam logic [7:0] XgmiiSfd      = 8'hD5;

   localparam logic [63:0] StartWord = {XgmiiSfd, {6{XgmiiPreamble}}, XgmiiStart};
   localparam logic [7:0]  StartCtrl = 8'h01;

   typedef enum logic {
      StIdle = 1'b0,
      StData = 1'b1
   } rx_state_e;

   // Lowest lane flagged as control; 0 when no lane is flagged.
   function automatic logic [2:0] first_ctrl_lane(input logic [7:0] ctrl);
      logic [2:0] lane;
      lane = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (ctrl[i]) lane = 3'(i);
      end
      return lane;
   endfunction

endpackage

// File: rtl/rx_lane_align.sv
// Two-stage XGMII input register and lane aligner: frames starting in lane 4
// are shifted by four bytes so every frame starts on a 64-bit word boundary.
module rx_lane_align
   import xgmii_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [63:0] rxd64_i,
   input  logic [7:0]  rxc8_i,
   output logic [63:0] data_o,
   output logic [7:0]  ctrl_o
);

   logic [71:0] r0_q, r1_q;
   logic        shift_q, shift_d;

   // The flag is decided from r0 so it switches exactly when r1 holds the start word.
   always_comb begin
      shift_d = shift_q;
      if (r0_q[64] && (r0_q[7:0] == XgmiiStart)) begin
         shift_d = 1'b0;
      end else if (r0_q[68] && (r0_q[39:32] == XgmiiStart)) begin
         shift_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r0_q    <= '0;
         r1_q    <= '0;
         shift_q <= 1'b0;
      end else begin
         r0_q    <= {rxc8_i, rxd64_i};
         r1_q    <= r0_q;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      if (shift_q) begin
         data_o = {r0_q[31:0], r1_q[63:32]};
         ctrl_o = {r0_q[67:64], r1_q[71:68]};
      end else begin
         data_o = r1_q[63:0];
         ctrl_o = r1_q[71:64];
      end
   end

endmodule

// File: rtl/rx_frame_detect.sv
// XGMII receive frame delineator: finds aligned start words, tracks frame data
// and raises terminator / error strobes for the downstream CRC checker.
module rx_frame_detect
   import xgmii_pkg::*;
#(
   parameter int unsigned TP = 1
) (
   input  logic        rxclk,
   input  logic        reset,
   input  logic [63:0] rxd64,
   input  logic [7:0]  rxc8,
   output logic [63:0] rxd64_d2,
   output logic        receiving_d1,
   output logic        receiving_d2,
   output logic        get_terminator,
   output logic [2:0]  terminator_location,
   output logic        wait_crc_check,
   output logic        frame_error
);

   // TP only delays assignments in behavioural models; nothing to delay here.
   logic tp_unused;
   assign tp_unused = ^TP;

   logic [63:0] a_data;
   logic [7:0]  a_ctrl;
   logic [2:0]  ctrl_lane;

   rx_state_e   state_q, state_d;
   logic [63:0] rxd64_d1_q, rxd64_d2_q;
   logic        rcv_d1_q, rcv_d2_q, rcv_d;
   logic        term_q, term_d;
   logic        err_q, err_d;
   logic [2:0]  loc_q, loc_d;
   logic [1:0]  crc_cnt_q, crc_cnt_d;

   rx_lane_align u_align (
      .clk_i   (rxclk),
      .rst_i   (reset),
      .rxd64_i (rxd64),
      .rxc8_i  (rxc8),
      .data_o  (a_data),
      .ctrl_o  (a_ctrl)
   );

   always_comb begin
      ctrl_lane = first_ctrl_lane(a_ctrl);
      state_d   = state_q;
      rcv_d     = 1'b0;
      term_d    = 1'b0;
      err_d     = 1'b0;
      loc_d     = loc_q;
      unique case (state_q)
         StIdle: begin
            if ((a_ctrl == StartCtrl) && (a_data == StartWord)) state_d = StData;
         end
         StData: begin
            if (a_ctrl == 8'h00) begin
               rcv_d = 1'b1;
            end else begin
               state_d = StIdle;
               // Only the lowest control lane matters; anything above /T/ is ignored.
               if (a_data[{ctrl_lane, 3'b000} +: 8] == XgmiiTerm) begin
                  term_d = 1'b1;
                  loc_d  = ctrl_lane;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      if (term_q) begin
         crc_cnt_d = 2'd3;
      end else if (crc_cnt_q != 2'd0) begin
         crc_cnt_d = crc_cnt_q - 2'd1;
      end else begin
         crc_cnt_d = 2'd0;
      end
   end

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         rxd64_d1_q <= '0;
         rxd64_d2_q <= '0;
         rcv_d1_q   <= 1'b0;
         rcv_d2_q   <= 1'b0;
         term_q     <= 1'b0;
         err_q      <= 1'b0;
         loc_q      <= 3'd0;
         crc_cnt_q  <= 2'd0;
      end else begin
         state_q    <= state_d;
         rxd64_d1_q <= a_data;
         rxd64_d2_q <= rxd64_d1_q;
         rcv_d1_q   <= rcv_d;
         rcv_d2_q   <= rcv_d1_q;
         term_q     <= term_d;
         err_q      <= err_d;
         loc_q      <= loc_d;
         crc_cnt_q  <= crc_cnt_d;
      end
   end

   assign rxd64_d2            = rxd64_d2_q;
   assign receiving_d1        = rcv_d1_q;
   assign receiving_d2        = rcv_d2_q;
   assign get_terminator      = term_q;
   assign terminator_location = loc_q;
   assign frame_error         = err_q;
   assign wait_crc_check      = term_q | (crc_cnt_q != 2'd0);

endmodule

// File: tb/tb_rx_frame_detect.sv
// Self-checking bench for rx_frame_detect: frames are built as byte streams and
// the expected aligned words, terminator lanes and strobes are derived from them.
module tb_rx_frame_detect;

   logic        rxclk = 1'b0;
   logic        reset;
   logic [63:0] rxd64;
   logic [7:0]  rxc8;
   logic [63:0] rxd64_d2;
   logic        receiving_d1, receiving_d2, get_terminator, wait_crc_check, frame_error;
   logic [2:0]  terminator_location;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int base  = 0;

   always #5 rxclk = ~rxclk;
   always @(posedge rxclk) cyc <= cyc + 1;

   rx_frame_detect dut (
      .rxclk               (rxclk),
      .reset               (reset),
      .rxd64               (rxd64),
      .rxc8                (rxc8),
      .rxd64_d2            (rxd64_d2),
      .receiving_d1        (receiving_d1),
      .receiving_d2        (receiving_d2),
      .get_terminator      (get_terminator),
      .terminator_location (terminator_location),
      .wait_crc_check      (wait_crc_check),
      .frame_error         (frame_error)
   );

   typedef struct {
      int sp;
      int len;
      int err;
      bit bad;
   } frame_t;

   logic [8:0]  bs[$];
   frame_t      frames[$];
   logic [63:0] exp_words[$], exp_tw[$];
   int          exp_locs[$], exp_rise[$];
   int          exp_errs;

   logic [63:0] got_words[$], got_tw[$];
   int          got_locs[$], got_rise[$];
   int          got_errs = 0, wcc_hi = 0, viol = 0;
   bit          tw_pend = 1'b0, rd1_prev = 1'b0;

   always @(negedge rxclk) begin
      if (tw_pend) got_tw.push_back(rxd64_d2);
      tw_pend = get_terminator;
      if (receiving_d2) got_words.push_back(rxd64_d2);
      if (get_terminator) got_locs.push_back(int'(terminator_location));
      if (frame_error) got_errs = got_errs + 1;
      if (wait_crc_check) wcc_hi = wcc_hi + 1;
      if ((get_terminator || frame_error) && receiving_d1) viol = viol + 1;
      if (receiving_d1 && !rd1_prev) got_rise.push_back(cyc - base);
      rd1_prev = receiving_d1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_b(input bit c, input logic [7:0] b);
      bs.push_back({c, b});
   endtask

   task automatic pad_to(input int m);
      while ((bs.size() % 8) != m) push_b(1'b1, 8'h07);
   endtask

   // Frame = start, preamble, SFD (bad -> 0xD4), payload (0xFE control at err), /T/.
   task automatic add_frame(input bit lane4, input int len, input int err, input bit bad,
                            input int gap);
      frame_t f;
      pad_to(0);
      repeat (gap * 8) push_b(1'b1, 8'h07);
      if (lane4) repeat (4) push_b(1'b1, 8'h07);
      f.sp  = bs.size();
      f.len = len;
      f.err = err;
      f.bad = bad;
      push_b(1'b1, 8'hFB);
      repeat (6) push_b(1'b0, 8'h55);
      push_b(1'b0, bad ? 8'hD4 : 8'hD5);
      for (int i = 0; i < len; i++) begin
         if (i == err) push_b(1'b1, 8'hFE);
         else push_b(1'b0, 8'($urandom));
      end
      push_b(1'b1, 8'hFD);
      frames.push_back(f);
   endtask

   task automatic finish_stream;
      pad_to(0);
      repeat (32) push_b(1'b1, 8'h07);
   endtask

   function automatic logic [63:0] word_at(input int p);
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = bs[p+k][7:0];
      return w;
   endfunction

   task automatic build_exp(input int first);
      for (int i = first; i < frames.size(); i++) begin
         frame_t f;
         int     nfull;
         f = frames[i];
         if (!f.bad) begin
            nfull = (f.err >= 0) ? f.err / 8 : f.len / 8;
            for (int j = 1; j <= nfull; j++) exp_words.push_back(word_at(f.sp + 8*j));
            if (nfull > 0) exp_rise.push_back(f.sp / 8 + 4);
            if (f.err >= 0) begin
               exp_errs++;
            end else begin
               exp_locs.push_back(f.len % 8);
               exp_tw.push_back(word_at(f.sp + 8*(f.len/8 + 1)));
            end
         end
      end
   endtask

   task automatic drive_words(input int from, input int to);
      for (int w = from; w < to; w++) begin
         @(posedge rxclk);
         #1;
         if (w == from) base = cyc - from;
         for (int k = 0; k < 8; k++) begin
            rxd64[8*k +: 8] = bs[8*w + k][7:0];
            rxc8[k]         = bs[8*w + k][8];
         end
      end
   endtask

   task automatic drain;
      @(posedge rxclk);
      #1;
      rxd64 = {8{8'h07}};
      rxc8  = 8'hFF;
      repeat (10) @(posedge rxclk);
      #1;
   endtask

   task automatic clear_got;
      got_words.delete();
      got_tw.delete();
      got_locs.delete();
      got_rise.delete();
      got_errs = 0;
      wcc_hi   = 0;
      viol     = 0;
   endtask

   task automatic check_run(input string ph);
      chk({ph, ".nwords"}, 64'(got_words.size()), 64'(exp_words.size()));
      for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
         chk({ph, ".word"}, got_words[i], exp_words[i]);
      chk({ph, ".nterm"}, 64'(got_locs.size()), 64'(exp_locs.size()));
      for (int i = 0; i < exp_locs.size() && i < got_locs.size(); i++)
         chk({ph, ".loc"}, 64'(got_locs[i]), 64'(exp_locs[i]));
      for (int i = 0; i < exp_tw.size() && i < got_tw.size(); i++)
         chk({ph, ".termword"}, got_tw[i], exp_tw[i]);
      chk({ph, ".nrise"}, 64'(got_rise.size()), 64'(exp_rise.size()));
      for (int i = 0; i < exp_rise.size() && i < got_rise.size(); i++)
         chk({ph, ".latency"}, 64'(got_rise[i]), 64'(exp_rise[i]));
      chk({ph, ".frame_error"}, 64'(got_errs), 64'(exp_errs));
      chk({ph, ".wcc_cycles"}, 64'(wcc_hi), 64'(4 * exp_locs.size()));
      chk({ph, ".rcv_with_strobe"}, 64'(viol), 64'd0);
      bs.delete();
      frames.delete();
      exp_words.delete();
      exp_tw.delete();
      exp_locs.delete();
      exp_rise.delete();
      exp_errs = 0;
      clear_got();
   endtask

   task automatic chk_all_zero(input string ph);
      chk({ph, ".rxd64_d2"}, rxd64_d2, 64'd0);
      chk({ph, ".receiving_d1"}, 64'(receiving_d1), 64'd0);
      chk({ph, ".receiving_d2"}, 64'(receiving_d2), 64'd0);
      chk({ph, ".get_terminator"}, 64'(get_terminator), 64'd0);
      chk({ph, ".terminator_location"}, 64'(terminator_location), 64'd0);
      chk({ph, ".wait_crc_check"}, 64'(wait_crc_check), 64'd0);
      chk({ph, ".frame_error"}, 64'(frame_error), 64'd0);
   endtask

   initial begin
      int ws;
      exp_errs = 0;
      reset    = 1'b1;
      rxd64    = '0;
      rxc8     = '0;
      repeat (2) @(posedge rxclk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;

      // Directed frames: lane-0 8 words, lane-4 /T/ raw lane 1, /T/ lane 3,
      // 0xFE in raw lane 2 of the third data word, bad SFD, then a good frame.
      add_frame(1'b0, 64, -1, 1'b0, 1);
      add_frame(1'b1, 29, -1, 1'b0, 0);
      add_frame(1'b0, 27, -1, 1'b0, 1);
      add_frame(1'b0, 40, 18, 1'b0, 1);
      add_frame(1'b0, 32, -1, 1'b1, 1);
      add_frame(1'b1, 33, -1, 1'b0, 0);
      finish_stream();
      drive_words(0, bs.size() / 8);
      drain();
      build_exp(0);
      check_run("dir");

      // Random frames, random start lane, gaps including back-to-back.
      for (int n = 0; n < 16; n++) begin
         int len, kind, err;
         len  = 24 + int'($urandom % 57);
         kind = int'($urandom % 8);
         err  = (kind == 1 || kind == 2) ? 8 + int'($urandom % (len - 8)) : -1;
         add_frame(1'($urandom % 2), len, err, kind == 0, (n == 0) ? 1 : int'($urandom % 3));
      end
      finish_stream();
      drive_words(0, bs.size() / 8);
      drain();
      build_exp(0);
      check_run("rnd");

      // Reset asserted while the 5th data word is on the input.
      add_frame(1'b0, 64, -1, 1'b0, 1);
      add_frame(1'b1, 40, -1, 1'b0, 1);
      finish_stream();
      ws = frames[0].sp / 8 + 5;
      drive_words(0, ws + 1);
      chk("rstmid.pre_receiving_d2", 64'(receiving_d2), 64'd1);
      #1 reset = 1'b1;
      #1 chk_all_zero("rstmid");
      @(posedge rxclk);
      #1;
      @(posedge rxclk);
      #1;
      clear_got();
      reset = 1'b0;
      drive_words(ws + 1, bs.size() / 8);
      drain();
      build_exp(1);
      check_run("rstmid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
